// File: rtl/seg_pkg.sv
// Shared constants and types for the two-digit seven-segment scan driver.
package seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;

  // Segment patterns {g,f,e,d,c,b,a}, indexed by value; 10-15 show a dash.
  localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } dig_sel_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decode; non-BCD values show a dash.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0]       bcd_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = SEG_LUT[bcd_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver with shadow capture,
// leading-zero blanking and blink.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load,
  input  logic [3:0]       bcd_tens,
  input  logic [3:0]       bcd_ones,
  input  logic             blank_lead,
  input  logic             blink_en,
  output logic [SEG_W-1:0] seg,
  output logic [1:0]       dig_en
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_CW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_CW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_CW-1:0] blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  dig_sel_e            sel_q, sel_d;
  logic [3:0]          tens_q, tens_d;
  logic [3:0]          ones_q, ones_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                scan_wrap;
  logic [3:0]          cur_bcd;
  logic [SEG_W-1:0]    dec_seg;

  seg7_decode u_decode (
    .bcd_i (cur_bcd),
    .seg_o (dec_seg)
  );

  // seg is built from the next select so it changes on the same edge as
  // dig_en; the shadow feeding it is the registered copy (one cycle latency).
  always_comb begin
    scan_wrap     = (scan_cnt_q == SCAN_CW'(SCAN_DIV - 1));
    scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + SCAN_CW'(1);
    sel_d         = sel_q;
    if (scan_wrap) begin
      sel_d = (sel_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end

    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (blink_en) begin
      if (blink_cnt_q == BLINK_CW'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BLINK_CW'(1);
        blink_phase_d = blink_phase_q;
      end
    end

    tens_d = load ? bcd_tens : tens_q;
    ones_d = load ? bcd_ones : ones_q;

    cur_bcd = (sel_d == DIG_TENS) ? tens_q : ones_q;
    seg_d   = dec_seg;
    if ((sel_d == DIG_TENS) && blank_lead && (tens_q == 4'd0)) begin
      seg_d = SEG_BLANK;
    end
    if (blink_en && blink_phase_q) begin
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      sel_q         <= DIG_ONES;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      tens_q        <= 4'd0;
      ones_q        <= 4'd0;
      seg_q         <= SEG_BLANK;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      sel_q         <= sel_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      seg_q         <= seg_d;
    end
  end

  assign seg    = seg_q;
  assign dig_en = {sel_q == DIG_TENS, sel_q == DIG_ONES};

endmodule
